fft_bfly_scheduler: RTL

Address and control sequencer for the iterative in-place radix-2 DIT FFT core. It walks every stage and butterfly, and drives both read ports of the core's dual-port RAM (synchronous write, asynchronous read) with the operand pair. In parallel it gives the twiddle ROM its index and the butterfly datapath its stage number. It replays each address pair on the write side after a fixed datapath latency, and it inserts stage-boundary stalls so that no read sees stale data. Input samples are already in bit-reversed order in RAM when `start` is asserted.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_delay_line.sv | 29 ++
 rtl/fft_bfly_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types, defaults and butterfly address arithmetic for the FFT scheduler.
package fft_pkg;

    localparam int unsigned DefNLog2   = 9;
    localparam int unsigned DefPipeLat = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStall,
        StFlush,
        StFin
    } state_e;

    // Upper operand address of butterfly j in stage s.
    function automatic logic [31:0] bfly_addr_a(input logic [31:0] s, input logic [31:0] j);
        logic [31:0] half;
        half = 32'd1 << s;
        return ((j >> s) << (s + 32'd1)) | (j & (half - 32'd1));
    endfunction

    // Lower operand address; the upper address has bit s clear, so this never carries.
    function automatic logic [31:0] bfly_addr_b(input logic [31:0] s, input logic [31:0] j);
        return bfly_addr_a(s, j) + (32'd1 << s);
    endfunction

    // Twiddle index k << (n_log2-1-s); the caller truncates to n_log2-1 bits.
    function automatic logic [31:0] bfly_tw(input logic [31:0] n_log2, input logic [31:0] s,
                                            input logic [31:0] j);
        return (j & ((32'd1 << s) - 32'd1)) << (n_log2 - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with a shared freeze enable.
module fft_delay_line #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Depth-1:0][Width-1:0] pipe_q;

    // Advance one slot per un-held cycle; reset discards every in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else if (!hold_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: read pairs, twiddle
// index, stage number, and write-back replay delayed by the datapath latency.
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2   = DefNLog2,
    parameter int unsigned PIPE_LAT = DefPipeLat
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        hold_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        rd_en_o,
    output logic [N_LOG2-1:0]           rd_addr_a_o,
    output logic [N_LOG2-1:0]           rd_addr_b_o,
    output logic [N_LOG2-2:0]           tw_addr_o,
    output logic [$clog2(N_LOG2)-1:0]   stage_o,
    output logic                        wr_en_o,
    output logic [N_LOG2-1:0]           wr_addr_a_o,
    output logic [N_LOG2-1:0]           wr_addr_b_o
);

    localparam int unsigned SW = $clog2(N_LOG2);
    localparam int unsigned JW = N_LOG2 - 1;
    localparam int unsigned CW = $clog2(PIPE_LAT + 1);
    localparam int unsigned DW = 1 + 2 * N_LOG2;

    localparam logic [JW-1:0] JLast = {JW{1'b1}};
    localparam logic [SW-1:0] SLast = SW'(N_LOG2 - 1);
    localparam logic [CW-1:0] CLast = CW'(PIPE_LAT - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [JW-1:0]     j_q, j_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [N_LOG2-1:0] addr_a_q, addr_a_d;
    logic [N_LOG2-1:0] addr_b_q, addr_b_d;
    logic [JW-1:0]     tw_q, tw_d;
    logic              issue;
    logic [DW-1:0]     wr_bus;

    // Next-state and registered-output decode; a pair is loaded only when one issues.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    s_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    issue   = 1'b1;
                end
            end
            StRun: begin
                if (j_q == JLast) begin
                    cnt_d   = '0;
                    state_d = (s_q == SLast) ? StFlush : StStall;
                end else begin
                    j_d   = j_q + JW'(1);
                    issue = 1'b1;
                end
            end
            StStall: begin
                if (cnt_q == CLast) begin
                    state_d = StRun;
                    s_d     = s_q + SW'(1);
                    j_d     = '0;
                    issue   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFlush: begin
                if (cnt_q == CLast) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        rd_en_d  = issue;
        addr_a_d = issue ? N_LOG2'(bfly_addr_a(32'(s_d), 32'(j_d))) : addr_a_q;
        addr_b_d = issue ? N_LOG2'(bfly_addr_b(32'(s_d), 32'(j_d))) : addr_b_q;
        tw_d     = issue ? JW'(bfly_tw(32'(N_LOG2), 32'(s_d), 32'(j_d))) : tw_q;
    end

    // State and output registers; hold freezes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            s_q      <= '0;
            j_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else if (!hold_i) begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    fft_delay_line #(
        .Width (DW),
        .Depth (PIPE_LAT)
    ) u_wr_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .hold_i (hold_i),
        .d_i    ({rd_en_q, addr_a_q, addr_b_q}),
        .q_o    (wr_bus)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = addr_a_q;
    assign rd_addr_b_o = addr_b_q;
    assign tw_addr_o   = tw_q;
    assign stage_o     = s_q;
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = wr_bus;

endmodule
